// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
//   Shared definitions for the TDM receive demultiplexer.
//   - ST_HUNT / ST_LOCK : framing state encoding
//   - LANES_DEF / WIDTH_DEF : default slots per frame and bits per slot
//   - slot_cnt_w() : width of the slot counter for a given lane count
// -----------------------------------------------------------------------------
package tdm_pkg;

    localparam logic ST_HUNT = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    localparam int LANES_DEF = 4;
    localparam int WIDTH_DEF = 1;

    // Slot counter width; never narrower than one bit.
    function automatic int slot_cnt_w(input int lanes);
        return (lanes < 2) ? 1 : $clog2(lanes);
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// -----------------------------------------------------------------------------
// tdm_slot_ctr
//   Modulo-LANES slot counter for the TDM demultiplexer.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   synchronous active-high reset (count -> 0)
//     i_clr    in   force count to 0
//     i_load1  in   force count to 1 (slot 0 just consumed)
//     i_adv    in   advance by one, wrapping LANES-1 -> 0
//     o_cnt    out  current slot index
//     o_wrap   out  high when o_cnt is the last slot (next advance wraps)
//   Priority: rst > i_clr > i_load1 > i_adv.
// -----------------------------------------------------------------------------
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int CW    = slot_cnt_w(LANES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_load1,
    input  logic          i_adv,
    output logic [CW-1:0] o_cnt,
    output logic          o_wrap
);

    logic [CW-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_wrap = (r_cnt == CW'(LANES - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= CW'(1);
        end else if (i_adv) begin
            r_cnt <= o_wrap ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
//   Receive side of a LANES:1 time-division link. Each strobed sample is
//   steered to the lane selected by the slot counter, aligned by fsync. A
//   completed frame is presented on dout with a one-cycle dout_vld pulse.
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   synchronous active-high reset
//     din       in   slot sample (WIDTH bits)
//     din_vld   in   slot strobe; din/fsync only sampled when high
//     fsync     in   marks current din as slot 0
//     lane_vld  out  one-hot pulse, lane just written
//     lane_dat  out  registered copy of the sample just written
//     dout      out  last complete frame, lane i = dout[i*WIDTH +: WIDTH]
//     dout_vld  out  one-cycle pulse, dout updated
//     locked    out  high while in LOCK
//     sync_err  out  one-cycle pulse on framing error
//     err_cnt   out  saturating sync_err count (only with TDM_DEMUX_ERRCNT_EN)
//   Build option: define TDM_DEMUX_ERRCNT_EN to add the err_cnt port/counter.
// -----------------------------------------------------------------------------
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_vld,
    input  logic                   fsync,
    output logic [LANES-1:0]       lane_vld,
    output logic [WIDTH-1:0]       lane_dat,
    output logic [LANES*WIDTH-1:0] dout,
    output logic                   dout_vld,
    output logic                   locked,
    output logic                   sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]             err_cnt
`endif
);

    localparam int CW = slot_cnt_w(LANES);

    logic                   r_state;
    logic [LANES*WIDTH-1:0] r_shadow;

    logic [CW-1:0]          w_cnt;
    logic                   w_wrap;
    logic                   w_next_state;
    logic                   w_write;
    logic                   w_to_lane0;
    logic                   w_adv;
    logic                   w_load1;
    logic                   w_clr;
    logic                   w_err;
    logic                   w_done;
    logic [CW-1:0]          w_slot;
    logic [LANES-1:0]       w_lane_oh;
    logic [LANES*WIDTH-1:0] w_frame;

    tdm_slot_ctr #(
        .LANES (LANES),
        .CW    (CW)
    ) u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_load1 (w_load1),
        .i_adv   (w_adv),
        .o_cnt   (w_cnt),
        .o_wrap  (w_wrap)
    );

    // Framing decisions for the current strobe.
    // NOTE: every signal gets a default before the branches so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_write      = 1'b0;
        w_to_lane0   = 1'b0;
        w_adv        = 1'b0;
        w_load1      = 1'b0;
        w_clr        = 1'b0;
        w_err        = 1'b0;
        w_done       = 1'b0;
        if (din_vld) begin
            if (r_state == ST_HUNT) begin
                if (fsync) begin
                    w_write      = 1'b1;
                    w_to_lane0   = 1'b1;
                    w_load1      = 1'b1;
                    w_next_state = ST_LOCK;
                end
            end else if (fsync) begin
                // Normal frame start, or early sync restarting the frame.
                w_write    = 1'b1;
                w_to_lane0 = 1'b1;
                w_load1    = 1'b1;
                w_err      = (w_cnt != '0);
            end else if (w_cnt == '0) begin
                // Slot 0 arrived without its marker: lose lock.
                w_err        = 1'b1;
                w_clr        = 1'b1;
                w_next_state = ST_HUNT;
            end else begin
                w_write = 1'b1;
                w_adv   = 1'b1;
                w_done  = w_wrap;
            end
        end
    end

    assign w_slot = w_to_lane0 ? '0 : w_cnt;

    // Shadow frame with the current sample merged in, plus the lane strobe.
    always_comb begin
        w_frame   = r_shadow;
        w_lane_oh = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_write && (CW'(i) == w_slot)) begin
                w_frame[i*WIDTH +: WIDTH] = din;
                w_lane_oh[i]              = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_HUNT;
            // NOTE: the shadow frame is reset on purpose: a frame completed
            // after reset must not expose lanes from before it.
            r_shadow <= '0;
            lane_vld <= '0;
            lane_dat <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            locked   <= (w_next_state == ST_LOCK);
            lane_vld <= w_lane_oh;
            dout_vld <= w_done;
            sync_err <= w_err;
            if (w_write) begin
                r_shadow <= w_frame;
                lane_dat <= din;
            end
            if (w_done) begin
                dout <= w_frame;
            end
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    // Saturating count of framing errors, in step with the sync_err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (w_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    // No error counter in this build.
`endif

endmodule
